uniform_mod_sampler: RTL and testbench
======================================

Name: uniform_mod_sampler

Overview:
- Downstream consumer of the Trivium random adapter: takes its free-running 64-bit random word stream (random_out / random_valid) and turns it into uniformly distributed coefficients in [0, q) by masked rejection sampling.
- Used to generate the uniform "a" polynomials for a single RNS prime q.
- Buffers accepted coefficients in a small FIFO and delivers them to the NTT/memory write path over a valid/ready handshake.
- The random source has no back-pressure, so surplus words are discarded.

Parameters:
- COEFF_W, 32: coefficient and modulus width. Each 64-bit random word yields two candidates; 2*COEFF_W must equal 64.
- CNT_W, 16: width of the coefficient-count request.
- FIFO_DEPTH, 4: output FIFO entries. Must be a power of two and at least 2.

Ports:
- clk, input, 1: clock. All logic is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- random_in, input, 64: random word (random_out of the adapter).
- random_valid, input, 1: random_in is valid this cycle.
- start, input, 1: one-cycle request pulse. Sampled only in IDLE.
- q, input, COEFF_W: modulus, sampled on start.
- n_coeffs, input, CNT_W: number of coefficients to produce, sampled on start.
- coeff_out, output, COEFF_W: FIFO head coefficient.
- coeff_valid, output, 1: FIFO is not empty.
- coeff_ready, input, 1: downstream accepts coeff_out when coeff_valid && coeff_ready.
- busy, output, 1: high in any state other than IDLE.
- done, output, 1: one-cycle pulse after the last coefficient has been popped.
- err, output, 1: one-cycle pulse when start is rejected because q < 2.

Behaviour:
- Reset (asynchronous, active when rst_n = 0), all of the following clear immediately, including mid-run:
  - State goes to IDLE.
  - FIFO is emptied (pointers and count zeroed).
  - coeff_out = 0, coeff_valid = 0, busy = 0, done = 0, err = 0.
  - Internal q_r, mask_r and remaining = 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start with q >= 2: latch q_r = q and remaining = n_coeffs, and set mask_r to all ones from bit 0 up to and including the MSB of (q-1). Example: q = 12289 gives mask = 0x3FFF.
  - Next state is RUN, or DRAIN if n_coeffs = 0.
  - start with q < 2: err pulses for 1 cycle, state stays IDLE, nothing is latched.
- RUN, per cycle:
  - A word is consumed only if random_valid = 1, remaining != 0 and FIFO free slots >= 2, evaluated before this cycle's pop.
  - Otherwise the word is discarded with no state change.
  - Lane 0 is c0 = random_in[COEFF_W-1:0] & mask_r. Lane 1 is c1 = random_in[63:COEFF_W] & mask_r.
  - A lane is accepted iff its value < q_r (unsigned compare).
  - Accepted lanes are pushed in the same cycle, lane 0 before lane 1.
  - If remaining = 1 and both lanes are accepted, only lane 0 is pushed and lane 1 is dropped.
  - remaining decrements by the number pushed (0, 1 or 2).
  - When remaining reaches 0, the next state is DRAIN.
- DRAIN: wait until the FIFO is empty, then go to DONE.
- DONE: assert done for exactly 1 cycle, then go to IDLE; busy drops in the IDLE cycle.
- Latency: a word accepted in cycle t gives coeff_valid = 1 in cycle t+1 (registered FIFO output).
- FIFO:
  - Push and pop in the same cycle are both honoured, so the count changes by (pushes - pops).
  - No push is ever attempted when fewer than 2 slots are free, so overflow is impossible.
  - A pop with coeff_valid = 0 is ignored.
  - coeff_out holds its value while coeff_valid && !coeff_ready.
- start while busy is ignored: no err, no relatch.
- Each of the total n_coeffs coefficients is delivered exactly once, in acceptance order.

Test Plan:
- q = 12289, n_coeffs = 4, coeff_ready = 1, words 0x0000_1000_0000_0005 and then 0x0000_3FFF_0000_2FFF:
  - Word 1: mask = 0x3FFF, both lanes accepted, output 5 then 0x1000.
  - Word 2: 0x2FFF is accepted and 0x3FFF >= 12289 is rejected.
  - Any accepted lane 0 of a third word completes the 4 coefficients; done pulses once after the 4th pop.
- remaining = 1 with word {0x0000_0002, 0x0000_0001} and q = 12289: only 1 is output, 2 is dropped, state goes to DRAIN.
- coeff_ready = 0 for 10 cycles, random_valid = 1 continuously, q = 0xFFFF_FFFB:
  - FIFO fills to at most 4 and further words are discarded.
  - After coeff_ready is released, the count and order of the delivered coefficients are correct with no duplicates.
- start with q = 1 while IDLE: err pulses 1 cycle, busy stays 0. start with n_coeffs = 0, q = 17: busy high, then done 2 cycles after start.
- rst_n pulled low mid-RUN while the FIFO holds 3 entries: coeff_valid = 0 and busy = 0 immediately, without waiting for a clock edge. A new start after rst_n rises completes normally.
- Random regression, q = 12289, n = 4096, random coeff_ready: every output is < 12289, exactly 4096 outputs, and the sequence matches the reference model.

Source files
------------

// File: rtl/uniform_mod_sampler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uniform_mod_sampler
//
// Turns the free-running 64-bit random word stream of the Trivium adapter into
// coefficients uniformly distributed in [0, q) by masked rejection sampling.
// Every word yields two candidates; each is masked down to the bit length of
// (q-1) and kept only if it is below q. Accepted coefficients are queued in a
// small FIFO and handed to the NTT/memory write path over valid/ready. The
// random source cannot be stalled, so words that arrive while the FIFO is short
// of room (or once the request is satisfied) are simply dropped.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   random_in     64-bit random word
//   random_valid  random_in is valid this cycle
//   start         one-cycle request pulse, honoured only when idle
//   q             modulus, captured on start (must be >= 2)
//   n_coeffs      number of coefficients to deliver, captured on start
//   coeff_out     FIFO head coefficient (0 while the FIFO is empty)
//   coeff_valid   FIFO not empty
//   coeff_ready   downstream accepts coeff_out this cycle
//   busy          a request is in progress
//   done          one-cycle pulse after the last coefficient has been popped
//   err           one-cycle pulse when a start is rejected for q < 2
// -----------------------------------------------------------------------------
module uniform_mod_sampler #(
   parameter int COEFF_W    = 32,
   parameter int CNT_W      = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [63:0]        random_in,
   input  logic               random_valid,
   input  logic               start,
   input  logic [COEFF_W-1:0] q,
   input  logic [CNT_W-1:0]   n_coeffs,
   output logic [COEFF_W-1:0] coeff_out,
   output logic               coeff_valid,
   input  logic               coeff_ready,
   output logic               busy,
   output logic               done,
   output logic               err
);

   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_FW = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Mask covering every bit up to and including the MSB of (qv - 1):
   // smear the top set bit downwards with doubling shifts.
   function automatic logic [COEFF_W-1:0] f_mask(input logic [COEFF_W-1:0] qv);
      logic [COEFF_W-1:0] m;
      m = qv - COEFF_W'(1);
      for (int s = 1; s < COEFF_W; s = s * 2) begin
         m = m | (m >> s);
      end
      return m;
   endfunction

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t             r_state;
   logic [COEFF_W-1:0] r_q;
   logic [COEFF_W-1:0] r_mask;
   logic [CNT_W-1:0]   r_remaining;
   logic               r_busy;
   logic               r_done;
   logic               r_err;

   logic [COEFF_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_FW-1:0]  r_count;

   // ---------------------------------------------------------------------------
   // Candidate extraction and acceptance
   // ---------------------------------------------------------------------------
   logic [COEFF_W-1:0] w_c0;
   logic [COEFF_W-1:0] w_c1;
   logic               w_acc0;
   logic               w_acc1;
   logic [CNT_FW-1:0]  w_free;
   logic               w_consume;
   logic [1:0]         w_npush;
   logic [COEFF_W-1:0] w_slot0;
   logic [COEFF_W-1:0] w_slot1;
   logic               w_pop;
   logic [PTR_W-1:0]   w_wr_ptr1;

   assign w_c0   = random_in[COEFF_W-1:0] & r_mask;
   assign w_c1   = random_in[2*COEFF_W-1:COEFF_W] & r_mask;
   assign w_acc0 = (w_c0 < r_q);
   assign w_acc1 = (w_c1 < r_q);

   // Room is judged before this cycle's pop, so two free slots always
   // guarantee that a double push fits regardless of downstream behaviour.
   assign w_free    = CNT_FW'(FIFO_DEPTH) - r_count;
   assign w_consume = (r_state == S_RUN) && random_valid &&
                      (r_remaining != '0) && (w_free >= CNT_FW'(2));

   assign w_pop     = (r_count != '0) && coeff_ready;
   assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);

   // Lane 0 always goes first. When only lane 1 survives it takes the first
   // write slot; when one coefficient is still owed, lane 1 is discarded.
   always_comb begin
      w_npush = 2'd0;
      w_slot0 = w_c0;
      w_slot1 = w_c1;
      if (w_consume) begin
         if (w_acc0 && w_acc1) begin
            w_npush = (r_remaining == CNT_W'(1)) ? 2'd1 : 2'd2;
         end else if (w_acc0) begin
            w_npush = 2'd1;
         end else if (w_acc1) begin
            w_npush = 2'd1;
            w_slot0 = w_c1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_q         <= '0;
         r_mask      <= '0;
         r_remaining <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (q < COEFF_W'(2)) begin
                     r_err <= 1'b1;
                  end else begin
                     r_q         <= q;
                     r_mask      <= f_mask(q);
                     r_remaining <= n_coeffs;
                     r_busy      <= 1'b1;
                     r_state     <= (n_coeffs == '0) ? S_DRAIN : S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (w_consume) begin
                  r_remaining <= r_remaining - CNT_W'(w_npush);
                  if (r_remaining == CNT_W'(w_npush)) begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (r_count == '0) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output FIFO: pointers and occupancy
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_npush);
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_FW'(w_npush) - CNT_FW'(w_pop);
      end
   end

   // Storage is data only; emptiness is tracked by the pointers above.
   always_ff @(posedge clk) begin
      if (w_npush != 2'd0) begin
         r_mem[r_wr_ptr] <= w_slot0;
      end
      if (w_npush == 2'd2) begin
         r_mem[w_wr_ptr1] <= w_slot1;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   // The head is gated by occupancy so the output reads 0 as soon as the
   // (asynchronously cleared) count says the FIFO is empty.
   assign coeff_valid = (r_count != '0);
   assign coeff_out   = coeff_valid ? r_mem[r_rd_ptr] : '0;
   assign busy        = r_busy;
   assign done        = r_done;
   assign err         = r_err;

endmodule

// File: tb/tb_uniform_mod_sampler.sv
`timescale 1ns/1ps
module tb_uniform_mod_sampler;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] random_in = '0;
   logic        random_valid = 1'b0;
   logic        start = 1'b0;
   logic [31:0] q = '0;
   logic [15:0] n_coeffs = '0;
   logic [31:0] coeff_out;
   logic        coeff_valid;
   logic        coeff_ready = 1'b1;
   logic        busy;
   logic        done;
   logic        err;

   uniform_mod_sampler #(.COEFF_W(32), .CNT_W(16), .FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .random_in   (random_in),
      .random_valid(random_valid),
      .start       (start),
      .q           (q),
      .n_coeffs    (n_coeffs),
      .coeff_out   (coeff_out),
      .coeff_valid (coeff_valid),
      .coeff_ready (coeff_ready),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] q;
      logic [15:0] n;
      logic [63:0] w;
      int          cnt;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   vec_t vecs [9];

   // reference model state
   logic [31:0] mq [$];
   logic [31:0] got_q [$];
   logic [63:0] word_q [$];
   int unsigned m_rem;
   logic [31:0] m_mask;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bit length of (q-1) found by scanning for its highest set bit.
   function automatic logic [31:0] ref_mask(input logic [31:0] qq);
      logic [31:0] d;
      logic [32:0] m;
      int msb;
      d = qq - 32'd1;
      msb = 0;
      for (int b = 0; b < 32; b++) if (d[b]) msb = b;
      m = (33'd1 << (msb + 1)) - 33'd1;
      return m[31:0];
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      random_valid = 1'b0;
      @(negedge clk);
      chk1("rst_valid", coeff_valid, 1'b0);
      chk32("rst_out", coeff_out, 32'd0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_done", done, 1'b0);
      chk1("rst_err", err, 1'b0);
      #2 rst_n = 1'b1;
      tick();
   endtask

   // rdy_mode: 0 always ready, 1 random, 2 stalled for the first cycles then ready
   task automatic run_job(input logic [31:0] jq, input logic [15:0] jn, input int rdy_mode,
                          input int rv_pct, input bit poke, input int max_cyc);
      bit done_seen;
      bit fin;
      int delivered;
      int npend;
      logic [31:0] pend [2];
      logic [31:0] c0;
      logic [31:0] c1;
      logic [31:0] g;
      mq.delete();
      got_q.delete();
      m_rem = 0;
      m_mask = ref_mask(jq);
      done_seen = 0;
      fin = 0;
      delivered = 0;
      for (int k = 0; k < max_cyc && !fin; k++) begin
         start = (k == 0) || (poke && k == 3);
         q = (poke && k == 3) ? 32'd1 : jq;
         n_coeffs = jn;
         random_valid = (k == 0) ? 1'b0 : (int'($urandom_range(99)) < rv_pct);
         if (random_valid && word_q.size() > 0) random_in = word_q.pop_front();
         else random_in = {$urandom(), $urandom()};
         coeff_ready = (rdy_mode == 0) ? 1'b1 :
                       (rdy_mode == 1) ? 1'($urandom_range(1)) : (k >= 11);
         @(negedge clk);
         chk1("coeff_valid", coeff_valid, mq.size() != 0);
         if (mq.size() != 0) chk32("coeff_out", coeff_out, mq[0]);
         chk1("err_busy", err, 1'b0);
         if (done_seen) begin
            chk1("busy_after_done", busy, 1'b0);
            chk1("done_single", done, 1'b0);
            fin = 1;
         end else begin
            chk1("busy", busy, k >= 1);
            if (done) begin
               done_seen = 1;
               chk32("done_remaining", 32'(m_rem), 32'd0);
               chk32("done_fifo_empty", 32'(mq.size()), 32'd0);
               chk32("done_delivered", 32'(delivered), 32'(jn));
            end
            // next-state of the model: room judged before the pop
            npend = 0;
            if (random_valid && m_rem != 0 && (DEPTH - mq.size()) >= 2) begin
               c0 = random_in[31:0] & m_mask;
               c1 = random_in[63:32] & m_mask;
               if (c0 < jq) begin pend[npend] = c0; npend++; m_rem--; end
               if (m_rem != 0 && c1 < jq) begin pend[npend] = c1; npend++; m_rem--; end
            end
            if (mq.size() > 0 && coeff_ready) begin
               g = mq.pop_front();
               delivered++;
               chk1("out_below_q", g < jq, 1'b1);
               got_q.push_back(g);
            end
            for (int i = 0; i < npend; i++) mq.push_back(pend[i]);
            if (k == 0) m_rem = jn;
         end
         tick();
      end
      if (!fin) begin
         n_cmp++;
         n_bad++;
         $display("FAIL job_timeout: no done within %0d cycles (q=0x%0h n=%0d)", max_cyc, jq, jn);
      end
      start = 1'b0;
      random_valid = 1'b0;
      q = jq;
   endtask

   initial begin
      vecs[0] = '{32'd12289, 16'd4, 64'h0000_1000_0000_0005, 2, 32'h5, 32'h1000};
      vecs[1] = '{32'd12289, 16'd4, 64'h0000_3FFF_0000_2FFF, 1, 32'h2FFF, 32'h0};
      vecs[2] = '{32'd12289, 16'd1, 64'h0000_0002_0000_0001, 1, 32'h1, 32'h0};
      vecs[3] = '{32'd12289, 16'd4, 64'hFFFF_C001_0000_3001, 1, 32'h1, 32'h0};
      vecs[4] = '{32'd17, 16'd4, 64'h0000_0010_0000_0011, 1, 32'h10, 32'h0};
      vecs[5] = '{32'd2, 16'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2, 32'h0, 32'h1};
      vecs[6] = '{32'hFFFF_FFFB, 16'd3, 64'hFFFF_FFFA_FFFF_FFFB, 1, 32'hFFFF_FFFA, 32'h0};
      vecs[7] = '{32'd16, 16'd2, 64'h0000_001F_0000_0010, 2, 32'h0, 32'hF};
      vecs[8] = '{32'd3, 16'd2, 64'h0000_0003_0000_0007, 0, 32'h0, 32'h0};

      #3;
      do_reset();

      // single-word lane acceptance table
      for (int v = 0; v < 9; v++) begin
         coeff_ready = 1'b1;
         start = 1'b1; q = vecs[v].q; n_coeffs = vecs[v].n; random_valid = 1'b0;
         tick();
         start = 1'b0; random_in = vecs[v].w; random_valid = 1'b1;
         tick();
         random_valid = 1'b0;
         @(negedge clk);
         chk1($sformatf("vec%0d_valid0", v), coeff_valid, vecs[v].cnt >= 1);
         if (vecs[v].cnt >= 1) chk32($sformatf("vec%0d_out0", v), coeff_out, vecs[v].e0);
         tick();
         @(negedge clk);
         chk1($sformatf("vec%0d_valid1", v), coeff_valid, vecs[v].cnt == 2);
         if (vecs[v].cnt == 2) chk32($sformatf("vec%0d_out1", v), coeff_out, vecs[v].e1);
         tick();
         do_reset();
      end

      // q < 2 rejected
      start = 1'b1; q = 32'd1; n_coeffs = 16'd5;
      tick();
      start = 1'b0;
      @(negedge clk);
      chk1("err_pulse", err, 1'b1);
      chk1("err_busy", busy, 1'b0);
      tick();
      @(negedge clk);
      chk1("err_single", err, 1'b0);
      chk1("err_idle", busy, 1'b0);
      tick();

      // n_coeffs = 0: done two cycles after start
      start = 1'b1; q = 32'd17; n_coeffs = 16'd0;
      tick();
      start = 1'b0;
      @(negedge clk);
      chk1("n0_busy", busy, 1'b1);
      chk1("n0_done_early", done, 1'b0);
      tick();
      @(negedge clk);
      chk1("n0_done", done, 1'b1);
      tick();
      @(negedge clk);
      chk1("n0_done_end", done, 1'b0);
      chk1("n0_busy_end", busy, 1'b0);
      tick();

      // reference example: three words complete four coefficients
      word_q.delete();
      word_q.push_back(64'h0000_1000_0000_0005);
      word_q.push_back(64'h0000_3FFF_0000_2FFF);
      word_q.push_back(64'h0000_0000_0000_0007);
      run_job(32'd12289, 16'd4, 0, 100, 1'b0, 100);
      chk32("ex_count", 32'(got_q.size()), 32'd4);
      if (got_q.size() == 4) begin
         chk32("ex_c0", got_q[0], 32'h5);
         chk32("ex_c1", got_q[1], 32'h1000);
         chk32("ex_c2", got_q[2], 32'h2FFF);
         chk32("ex_c3", got_q[3], 32'h7);
      end
      word_q.delete();

      // back-pressure with a start poked while busy
      run_job(32'hFFFF_FFFB, 16'd20, 2, 100, 1'b1, 400);

      // asynchronous reset mid-run with three entries queued
      coeff_ready = 1'b0;
      start = 1'b1; q = 32'd12289; n_coeffs = 16'd100; random_valid = 1'b0;
      tick();
      start = 1'b0; random_valid = 1'b1; random_in = 64'h0000_0001_0000_0002;
      tick();
      random_in = 64'h0000_3FFF_0000_0003;
      tick();
      random_valid = 1'b0;
      @(negedge clk);
      chk1("pre_rst_valid", coeff_valid, 1'b1);
      chk32("pre_rst_head", coeff_out, 32'h2);
      chk1("pre_rst_busy", busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk1("async_rst_valid", coeff_valid, 1'b0);
      chk1("async_rst_busy", busy, 1'b0);
      chk32("async_rst_out", coeff_out, 32'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      run_job(32'd12289, 16'd8, 1, 80, 1'b0, 500);

      // random regression
      run_job(32'd12289, 16'd4096, 1, 75, 1'b0, 40000);
      chk32("regr_count", 32'(got_q.size()), 32'd4096);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
